// File: rtl/probe_pkg.sv
// Shared definitions for the probe sequencer: state encoding, LFSR
// polynomial, ILA field widths and the LFSR step function.
`timescale 1ns/1ps
package probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // ILA word is {state, mismatch, err_cnt, vec_idx, dut_sum}, MSB first.
  localparam int ILA_ERR_W   = 8;
  localparam int ILA_IDX_W   = 16;
  localparam int ILA_FIXED_W = 3 + 1 + ILA_ERR_W + ILA_IDX_W;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous level followed by a
// rising-edge detector producing a single-cycle pulse.
`timescale 1ns/1ps
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_p
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synced level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise_p = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/probe_sequencer.sv
// Drives pseudo-random operand pairs into the adder under test, checks the
// returned sum against a delayed reference and publishes status to the ILA.
`timescale 1ns/1ps
module probe_sequencer
  import probe_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          DUT_LATENCY = 2,
  parameter int          NUM_VEC     = 1024,
  parameter logic [31:0] SEED        = 32'hACE1_1234,
  parameter bit          STOP_ON_ERR = 1'b0,
  parameter int          ILA_W       = ILA_FIXED_W + DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        vio_ctrl,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  output logic              dut_vld,
  input  logic [DATA_W:0]   dut_sum,
  output logic [ILA_W-1:0]  ila_data,
  output logic [7:0]        trig0
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic [ILA_IDX_W-1:0] LAST_IDX = ILA_IDX_W'(NUM_VEC - 1);

  logic start_r, clear_r;

  sync_edge u_sync_start (.clk(clk), .rst_n(rst_n), .async_in(vio_ctrl[0]), .rise_p(start_r));
  sync_edge u_sync_clear (.clk(clk), .rst_n(rst_n), .async_in(vio_ctrl[1]), .rise_p(clear_r));

  state_e                 state_q, state_d, prev_state_q, prev_state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [ILA_IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [ILA_ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   mismatch_q, mismatch_d;
  logic [DUT_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [SUM_W-1:0]       exp_pipe_q [DUT_LATENCY];
  logic [SUM_W-1:0]       exp_pipe_d [DUT_LATENCY];
  logic [ILA_W-1:0]       ila_q, ila_d;
  logic [7:0]             trig_q, trig_d;

  logic issue, stop_hit, pipe_empty, checking;
  logic start_p, done_p, fail_p;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_state_q <= ST_IDLE;
    end else begin
      state_q      <= state_d;
      prev_state_q <= prev_state_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d      = state_q;
    prev_state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_r) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN: begin
        if (stop_hit)                   state_d = ST_FAIL;
        else if (vec_idx_q == LAST_IDX) state_d = ST_DRAIN;
      end
      // The last compare has landed in err_cnt once the valid pipe is empty.
      ST_DRAIN: begin
        if (stop_hit)        state_d = ST_FAIL;
        else if (pipe_empty) state_d = (err_cnt_q == '0) ? ST_DONE : ST_FAIL;
      end
      ST_DONE, ST_FAIL: state_d = state_q;
      default:          state_d = ST_IDLE;
    endcase
    if (clear_r) state_d = ST_IDLE;
  end

  // ---------------- outputs ----------------
  always_comb begin
    stop_hit   = STOP_ON_ERR && mismatch_q;
    pipe_empty = (vld_pipe_q == '0);
    checking   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    issue      = (state_q == ST_RUN) && !stop_hit;
    dut_vld    = issue;
    dut_a      = issue ? lfsr_q[DATA_W-1:0] : '0;
    dut_b      = issue ? lfsr_q[16+DATA_W-1:16] : '0;
    start_p    = (state_q == ST_LOAD);
    done_p     = (state_q == ST_DONE) && (prev_state_q != ST_DONE);
    fail_p     = (state_q == ST_FAIL) && (prev_state_q != ST_FAIL);
  end

  // ---------------- generator, reference pipe and checker ----------------
  always_comb begin
    lfsr_d        = lfsr_q;
    vec_idx_d     = vec_idx_q;
    err_cnt_d     = err_cnt_q;
    mismatch_d    = 1'b0;
    vld_pipe_d[0] = issue;
    exp_pipe_d[0] = SUM_W'(dut_a) + SUM_W'(dut_b);
    for (int i = 1; i < DUT_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      exp_pipe_d[i] = exp_pipe_q[i-1];
    end

    if (checking && vld_pipe_q[DUT_LATENCY-1] && (dut_sum != exp_pipe_q[DUT_LATENCY-1])) begin
      mismatch_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
    end

    if (issue) begin
      lfsr_d    = lfsr_step(lfsr_q);
      vec_idx_d = vec_idx_q + 16'd1;
    end

    if ((state_q == ST_LOAD) || clear_r) begin
      lfsr_d     = SEED;
      vec_idx_d  = '0;
      err_cnt_d  = '0;
      mismatch_d = 1'b0;
      vld_pipe_d = '0;
      for (int i = 0; i < DUT_LATENCY; i++) exp_pipe_d[i] = '0;
    end

    ila_d  = {state_q, mismatch_q, err_cnt_q, vec_idx_q, dut_sum};
    trig_d = {1'b0, state_q, fail_p, done_p, start_p, mismatch_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= SEED;
      vec_idx_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      vld_pipe_q <= '0;
      for (int i = 0; i < DUT_LATENCY; i++) exp_pipe_q[i] <= '0;
      ila_q      <= '0;
      trig_q     <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      vec_idx_q  <= vec_idx_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= mismatch_d;
      vld_pipe_q <= vld_pipe_d;
      for (int i = 0; i < DUT_LATENCY; i++) exp_pipe_q[i] <= exp_pipe_d[i];
      ila_q      <= ila_d;
      trig_q     <= trig_d;
    end
  end

  assign ila_data = ila_q;
  assign trig0    = trig_q;

endmodule

// File: doc/probe_sequencer.md
Name: probe_sequencer

Overview:
- Fabric-side counterpart of the chipscope debug wrapper. It consumes the two VIO control bits (start, clear) and drives the DUT with pseudo-random operand vectors.
- It checks the DUT sum against an internal delayed reference.
- It packs status into the 45-bit ILA data bus and the 8-bit ILA trigger bus.
- It sits between chipscope and the overclocked adder DUT in the test platform.

Parameters:
- DATA_W, 16, operand width (8..16); DUT result is DATA_W+1 bits.
- DUT_LATENCY, 2, DUT pipeline depth in cycles (1..8).
- NUM_VEC, 1024, vectors issued per run (1..65535).
- SEED, 32'hACE1_1234, LFSR seed; must be nonzero.
- STOP_ON_ERR, 0, 1 = go to FAIL on first mismatch.
- ILA_W, 28+DATA_W+1, derived; 45 at default.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- vio_ctrl  in  2  from VIO ASYNC_OUT, asynchronous to clk; [0]=start, [1]=clear.
- dut_a  out  DATA_W  operand A to DUT.
- dut_b  out  DATA_W  operand B to DUT.
- dut_vld  out  1  operands valid this cycle.
- dut_sum  in  DATA_W+1  DUT result, sampled DUT_LATENCY cycles after issue.
- ila_data  out  ILA_W  {state[2:0], mismatch, err_cnt[7:0], vec_idx[15:0], dut_sum}, MSB first.
- trig0  out  8  {1'b0, state[2:0], fail_p, done_p, start_p, mismatch}.

Behaviour:
- Reset (rst_n low, async): state=IDLE, LFSR=SEED, all counters/pipelines 0, dut_a/dut_b/dut_vld=0, mismatch=0, trig0=0, ila_data=0 except state field (IDLE=0).
- Sync: each vio_ctrl bit gets a 2-FF synchronizer plus rising-edge detect. Edges are internal 1-cycle pulses start_r and clear_r. Levels are ignored.
- State encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4, FAIL=5.
- IDLE: start_r -> LOAD.
- LOAD (1 cycle): LFSR<=SEED, vec_idx<=0, err_cnt<=0, pipelines cleared -> RUN. start_p=1 this cycle.
- RUN: one vector per cycle.
  - dut_vld=1, dut_a=lfsr[DATA_W-1:0], dut_b=lfsr[16+DATA_W-1:16].
  - LFSR advances as a Galois shift right, taps 0x80200003.
  - vec_idx increments. After the vector with vec_idx==NUM_VEC-1 -> DRAIN.
- DRAIN: dut_vld=0. Wait until the valid pipeline is empty and the final compare is registered, then go to DONE if err_cnt==0, else FAIL.
- DONE/FAIL: hold all status. done_p or fail_p pulses 1 cycle on entry.
- Clear: clear_r in any state -> IDLE next cycle. Counters, pipelines and mismatch are cleared. clear_r has priority over start_r and over all other transitions.
- Start while busy: start_r in LOAD/RUN/DRAIN is ignored. In DONE/FAIL it is ignored; clear is required first.
- Reference/check pipeline:
  - Expected value = dut_a+dut_b, width DATA_W+1, carried with dut_vld through a DUT_LATENCY-deep shift register.
  - A vector issued at cycle t is compared against dut_sum at t+DUT_LATENCY.
  - mismatch is registered and visible at t+DUT_LATENCY+1, as a 1-cycle pulse per bad vector.
- err_cnt increments on each mismatch and saturates at 255.
- STOP_ON_ERR=1: the first mismatch forces FAIL the cycle after mismatch is seen. dut_vld drops immediately and vec_idx freezes.
- ila_data and trig0 are fully registered, with 1 cycle latency from internal state.

Decomposition:
- Package probe_pkg: state encoding constants, LFSR polynomial constant, ILA field offsets/widths.
- Sub-module sync_edge (2-FF synchronizer + rising-edge detect, one instance per vio_ctrl bit).
- The LFSR and check pipeline stay in the top module.

Test Plan:
- Correct DUT: model dut_sum=a+b delayed 2 cycles, start pulse, NUM_VEC=16 -> 16 dut_vld cycles, DONE, err_cnt=0, done_p one cycle, first vector a=16'h1234, b=16'hACE1.
- Injected faults: model flips bit0 of sum on vectors 3 and 9 -> two mismatch pulses at issue+3 cycles each, FAIL, err_cnt=2, fail_p one cycle.
- STOP_ON_ERR=1 with error on vector 5 -> FAIL with vec_idx frozen ≤ 5+DUT_LATENCY+1, no further dut_vld, err_cnt=1.
- Saturation: every result wrong, NUM_VEC=300 -> err_cnt=255, FAIL.
- Clear mid-RUN (vector 7) -> IDLE next cycle, dut_vld=0, counters 0. A later start restarts with a=16'h1234.
- Async rst_n low mid-DRAIN -> all outputs to reset values immediately. Start pulse shorter than 2 clk cycles but ≥1 cycle wide is still detected exactly once.
